button_conditioner: RTL and testbench

//   Conditions the four raw board push-buttons (btnl, btnd, btnr, btnu) before the game logic uses them.
//   - Synchronises each button into the clk25 domain.
//   - Debounces each button.
//   - Emits, per button: a clean level, a one-cycle press pulse and a one-cycle release pulse.
//   - Sits between the top-level button pins and the game block (paddle movement).

---
 rtl/airhockey_pkg.sv | 27 ++
 rtl/button_conditioner_if.sv | 26 ++
 rtl/debounce_channel.sv | 112 +++++++++++
 rtl/button_conditioner.sv | 57 +++++
 tb/tb_button_conditioner.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/airhockey_pkg.sv
// Shared constants and types for the air-hockey button front end.
//   BTN_L/BTN_D/BTN_R/BTN_U : bit positions of each push-button in the button vectors
//   NUM_BTN_DEFAULT         : default number of button channels
//   CLK_HZ                  : game/pixel clock frequency (clk25)
//   ms_to_cycles()          : converts milliseconds to clk25 cycles
//   rpt_state_t             : auto-repeat FSM states
package airhockey_pkg;

  localparam int BTN_L = 0;
  localparam int BTN_D = 1;
  localparam int BTN_R = 2;
  localparam int BTN_U = 3;

  localparam int NUM_BTN_DEFAULT = 4;
  localparam int CLK_HZ          = 25_000_000;

  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the board pins / game logic and the conditioner.
//   btn_raw     : raw asynchronous button pins, active-high
//   btn_level   : debounced button state
//   btn_press   : one-cycle pulse on a debounced rising edge
//   btn_release : one-cycle pulse on a debounced falling edge
//   btn_repeat  : one-cycle auto-repeat pulses while a button is held
// Modports: master = pin/game side, slave = conditioner.
interface button_conditioner_if #(
  parameter int NUM_BTN = 4
);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] btn_repeat;

  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, btn_repeat
  );

  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, btn_repeat
  );
endinterface

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, saturating debounce counter,
// debounced level with press/release pulses and, when the macro
// BUTTON_CONDITIONER_REPEAT_EN is defined, an auto-repeat FSM.
//   clk   : clk25
//   rst_n : asynchronous reset, active-low
//   raw   : raw button pin
//   level : debounced state
//   press : 1-cycle pulse when level rises
//   rel   : 1-cycle pulse when level falls
//   rpt   : 1-cycle auto-repeat pulses (tied 0 without the macro)
module debounce_channel
  import airhockey_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
`ifdef BUTTON_CONDITIONER_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 3
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             commit;
  logic             level_nxt;

  // A change is accepted once sync has disagreed with level for DEBOUNCE_CYCLES cycles.
  assign commit    = (sync_p1 != level) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign level_nxt = commit ? sync_p1 : level;

  // Stage p0/p1: synchroniser; then debounce counter and level/pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
      rel     <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      level   <= level_nxt;
      press   <= commit &  sync_p1;
      rel     <= commit & ~sync_p1;
      // Clearing on agreement makes any glitch shorter than the window vanish.
      if ((sync_p1 == level) || commit) cnt <= '0;
      else                              cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef BUTTON_CONDITIONER_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW  = (RMAX > 1) ? $clog2(RMAX) : 1;

  rpt_state_t       state;
  logic [RCW-1:0]   rcnt;

  // Looking at level_nxt rather than level lets the FSM see the press and
  // release in the very cycle they commit, so no repeat pulse coincides
  // with a release pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rcnt  <= '0;
      rpt   <= 1'b0;
    end else begin
      rpt <= 1'b0;
      if (!level_nxt) begin
        state <= IDLE;
        rcnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (commit) begin
              state <= DELAY;
              rcnt  <= RCW'(REPEAT_DELAY - 1);
            end
          end
          DELAY, REPEAT: begin
            if (rcnt == '0) begin
              state <= REPEAT;
              rpt   <= 1'b1;
              rcnt  <= RCW'(REPEAT_PERIOD - 1);
            end else begin
              rcnt  <= rcnt - RCW'(1);
            end
          end
          default: begin
            state <= IDLE;
            rcnt  <= '0;
          end
        endcase
      end
    end
  end
`else
  assign rpt = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Conditions the board push-buttons for the game logic: synchronises each
// button into clk25, debounces it and produces level, press, release and
// (optionally) auto-repeat outputs per button. Bit order: [0]=btnl [1]=btnd
// [2]=btnr [3]=btnu.
// Optional feature: define BUTTON_CONDITIONER_REPEAT_EN to build the
// auto-repeat FSMs; otherwise btn_repeat is constant 0.
//   clk   : clk25
//   rst_n : asynchronous reset, active-low
//   bus   : button_conditioner_if.slave (btn_raw in; btn_level, btn_press,
//           btn_release, btn_repeat out)
module button_conditioner
  import airhockey_pkg::*;
#(
  parameter int NUM_BTN         = NUM_BTN_DEFAULT,
  parameter int DEBOUNCE_CYCLES = ms_to_cycles(10),
  parameter int REPEAT_DELAY    = ms_to_cycles(250),
  parameter int REPEAT_PERIOD   = ms_to_cycles(50)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  button_conditioner_if.slave  bus
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("button_conditioner: illegal timing parameters");
  end

  logic [NUM_BTN-1:0] level_v;
  logic [NUM_BTN-1:0] press_v;
  logic [NUM_BTN-1:0] rel_v;
  logic [NUM_BTN-1:0] rpt_v;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BUTTON_CONDITIONER_REPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (bus.btn_raw[i]),
      .level (level_v[i]),
      .press (press_v[i]),
      .rel   (rel_v[i]),
      .rpt   (rpt_v[i])
    );
  end

  assign bus.btn_level   = level_v;
  assign bus.btn_press   = press_v;
  assign bus.btn_release = rel_v;
  assign bus.btn_repeat  = rpt_v;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=8, REPEAT_PERIOD=3.
module tb_button_conditioner;

`ifdef BUTTON_CONDITIONER_REPEAT_EN
  localparam logic REP_EN = 1'b1;
`else
  localparam logic REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  button_conditioner_if #(.NUM_BTN(4)) bus ();

  button_conditioner #(
    .NUM_BTN         (4),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (8),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] raw;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] rpt;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(input int n, input logic [3:0] raw, input logic [3:0] lvl,
                              input logic [3:0] prs, input logic [3:0] rel,
                              input logic [3:0] rpt);
    vec_t v;
    v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel; v.rpt = rpt;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [3:0] act,
                       input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int idx, input logic [3:0] lvl,
                           input logic [3:0] prs, input logic [3:0] rel,
                           input logic [3:0] rpt);
    check({name, ".level"},   idx, bus.btn_level,   lvl);
    check({name, ".press"},   idx, bus.btn_press,   prs);
    check({name, ".release"}, idx, bus.btn_release, rel);
    check({name, ".repeat"},  idx, bus.btn_repeat,  rpt);
  endtask

  task automatic step(input logic [3:0] raw);
    bus.btn_raw = raw;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] rp;
    rp = REP_EN ? 4'h8 : 4'h0;

    // Reset with every button held, then release reset.
    rst_n       = 1'b0;
    bus.btn_raw = 4'hF;
    #1;
    check_all("reset_async", 0, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int k = 1; k <= 3; k++) begin
      step(4'hF);
      check_all("reset_hold", k, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step(4'hF);
      check_all("reset_release", k, (k >= 6) ? 4'hF : 4'h0, (k == 6) ? 4'hF : 4'h0,
                4'h0, 4'h0);
    end
    for (int k = 1; k <= 8; k++) begin
      step(4'h0);
      check_all("all_release", k, (k < 6) ? 4'hF : 4'h0, 4'h0,
                (k == 6) ? 4'hF : 4'h0, 4'h0);
    end

    // Channel 0 clean press, held, then released before any repeat.
    add(5, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0);
    add(5, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0);
    add(2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    // Channel 2 glitch of 3 cycles: nothing happens.
    add(3, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0);
    add(6, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    // Channel 1 bounce 1,0,1,0,1 then held: one press 5 steps after final rise.
    add(1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(5, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0);
    add(5, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0);
    add(2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    // Channel 3 held: repeats 8 after press then every 3; release lands on a
    // would-be repeat cycle, which must stay quiet.
    add(5, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0);
    add(7, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0);
    add(1, 4'h8, 4'h8, 4'h0, 4'h0, rp);
    add(2, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0);
    add(1, 4'h8, 4'h8, 4'h0, 4'h0, rp);
    add(2, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0);
    add(1, 4'h8, 4'h8, 4'h0, 4'h0, rp);
    add(2, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0);
    add(1, 4'h8, 4'h8, 4'h0, 4'h0, rp);
    add(2, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 4'h8, 4'h0, 4'h0, rp);
    add(2, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0);
    add(6, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    foreach (vecs[i]) begin
      step(vecs[i].raw);
      check_all("vec", i, vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].rpt);
    end

    // Reset in the middle of a debounce on channel 0 (counter at 2).
    for (int k = 1; k <= 4; k++) begin
      step(4'h1);
      check_all("mid_debounce", k, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    rst_n = 1'b0;
    #1;
    check_all("mid_reset_async", 0, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int k = 1; k <= 2; k++) begin
      step(4'h1);
      check_all("mid_reset_hold", k, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step(4'h1);
      check_all("after_mid_reset", k, (k >= 6) ? 4'h1 : 4'h0, (k == 6) ? 4'h1 : 4'h0,
                4'h0, 4'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
